cache_ctrl_wb: RTL and testbench

CACHE_CTRL_WB -- requirements
Module: cache_ctrl_wb

---
 rtl/cache_defs_pkg.sv | 16 +
 rtl/cache_stats.sv | 49 ++++
 rtl/cache_ctrl_wb.sv | 156 +++++++++++++++
 tb/tb_cache_ctrl_wb.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_defs_pkg.sv
// rtl/cache_defs_pkg.sv - shared cache definitions: controller state encoding and counter width default
// Contents:
//   state_e           2-bit controller state encoding, shared by the datapath and the controller
//   CNT_WIDTH_DEF     default width of the statistics counters
package cache_defs_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_e;

  localparam int CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/cache_stats.sv
// rtl/cache_stats.sv - saturating hit/miss counters for the write-back cache controller
// Ports:
//   clk, rst           clock, synchronous active-high reset (clears both counters)
//   hit_evt_i          one-cycle pulse: a request hit in its first lookup
//   miss_evt_i         one-cycle pulse: a request missed in its first lookup
//   hit_cnt_o          saturating hit count
//   miss_cnt_o         saturating miss count
module cache_stats
  import cache_defs_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hit_evt_i,
  input  logic                 miss_evt_i,
  output logic [CNT_WIDTH-1:0] hit_cnt_o,
  output logic [CNT_WIDTH-1:0] miss_cnt_o
);

  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_evt_i && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + 1'b1;
    end
    if (miss_evt_i && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: rtl/cache_ctrl_wb.sv
// rtl/cache_ctrl_wb.sv - write-back cache controller FSM (IDLE/COMPARE/WRITEBACK/ALLOCATE)
// Optional feature macro: CACHE_STATS_EN adds hit_cnt/miss_cnt statistics outputs.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_rd, cpu_wr           CPU request (write wins if both), held until cpu_ready
//   cpu_ready                one-cycle completion pulse
//   Hit, valid, dirty        set-memory status for the selected way
//   rd, wr, sel_all, dirty_wr  set-memory controls (sel_all=1: block write, 0: word write)
//   adr_sel                  0 = CPU address, 1 = write-back address
//   m_rd, m_wr, m_ready      block memory handshake
//   lru_update               pulse to record hit_way in the replacement policy
//   hit_cnt, miss_cnt        (CACHE_STATS_EN only) saturating first-lookup counters
module cache_ctrl_wb
  import cache_defs_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_rd,
  input  logic cpu_wr,
  output logic cpu_ready,
  input  logic Hit,
  input  logic valid,
  input  logic dirty,
  output logic rd,
  output logic wr,
  output logic sel_all,
  output logic dirty_wr,
  output logic adr_sel,
  output logic m_rd,
  output logic m_wr,
  input  logic m_ready,
  output logic lru_update
`ifdef CACHE_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
`endif
);

  state_e state_q, state_d;
  logic   req_wr_q, req_wr_d;
  // Set once a refill has been written; the following COMPARE is a re-check,
  // not a fresh lookup, so it is excluded from the statistics.
  logic   refilled_q, refilled_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_wr_q   <= 1'b0;
      refilled_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_wr_q   <= req_wr_d;
      refilled_q <= refilled_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_wr_d   = req_wr_q;
    refilled_d = refilled_q;
    cpu_ready  = 1'b0;
    rd         = 1'b0;
    wr         = 1'b0;
    sel_all    = 1'b0;
    dirty_wr   = 1'b0;
    adr_sel    = 1'b0;
    m_rd       = 1'b0;
    m_wr       = 1'b0;
    lru_update = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_rd || cpu_wr) begin
          req_wr_d   = cpu_wr;
          refilled_d = 1'b0;
          state_d    = COMPARE;
        end
      end
      COMPARE: begin
        rd = 1'b1;
        if (Hit) begin
          if (req_wr_q) begin
            wr       = 1'b1;
            sel_all  = 1'b0;
            dirty_wr = 1'b1;
          end
          cpu_ready  = 1'b1;
          lru_update = 1'b1;
          state_d    = IDLE;
        end else if (valid && dirty) begin
          // Also taken when a re-check after refill still misses, so a
          // faulty memory cannot wedge the FSM in COMPARE.
          state_d = WRITEBACK;
        end else begin
          state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        m_wr    = 1'b1;
        adr_sel = 1'b1;
        if (m_ready) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        m_rd    = 1'b1;
        adr_sel = 1'b0;
        if (m_ready) begin
          wr         = 1'b1;
          sel_all    = 1'b1;
          dirty_wr   = 1'b0;
          refilled_d = 1'b1;
          state_d    = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase

    // While reset is asserted nothing may reach the set or block memory,
    // even if m_ready lands in the same cycle.
    if (rst) begin
      cpu_ready  = 1'b0;
      rd         = 1'b0;
      wr         = 1'b0;
      sel_all    = 1'b0;
      dirty_wr   = 1'b0;
      adr_sel    = 1'b0;
      m_rd       = 1'b0;
      m_wr       = 1'b0;
      lru_update = 1'b0;
    end
  end

`ifdef CACHE_STATS_EN
  logic hit_evt;
  logic miss_evt;

  assign hit_evt  = (state_q == COMPARE) && Hit && !refilled_q && !rst;
  assign miss_evt = (state_q == COMPARE) && !Hit && !refilled_q && !rst;

  cache_stats #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stats (
    .clk       (clk),
    .rst       (rst),
    .hit_evt_i (hit_evt),
    .miss_evt_i(miss_evt),
    .hit_cnt_o (hit_cnt),
    .miss_cnt_o(miss_cnt)
  );
`endif

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// tb/tb_cache_ctrl_wb.sv - self-checking directed bench for cache_ctrl_wb
module tb_cache_ctrl_wb;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst, cpu_rd, cpu_wr, Hit, valid, dirty, m_ready;
  logic cpu_ready, rd, wr, sel_all, dirty_wr, adr_sel, m_rd, m_wr, lru_update;
`ifdef CACHE_STATS_EN
  logic [CW-1:0] hit_cnt, miss_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Output vector order: {cpu_ready, rd, wr, sel_all, dirty_wr, adr_sel, m_rd, m_wr, lru_update}
  logic [8:0] ov;
  assign ov = {cpu_ready, rd, wr, sel_all, dirty_wr, adr_sel, m_rd, m_wr, lru_update};

  localparam logic [8:0] O_ZERO   = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] O_RDHIT  = 9'b1_1_0_0_0_0_0_0_1;
  localparam logic [8:0] O_WRHIT  = 9'b1_1_1_0_1_0_0_0_1;
  localparam logic [8:0] O_CMPMIS = 9'b0_1_0_0_0_0_0_0_0;
  localparam logic [8:0] O_ALLOC  = 9'b0_0_0_0_0_0_1_0_0;
  localparam logic [8:0] O_REFILL = 9'b0_0_1_1_0_0_1_0_0;
  localparam logic [8:0] O_WB     = 9'b0_0_0_0_0_1_0_1_0;

  cache_ctrl_wb #(.CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_ready (cpu_ready),
    .Hit       (Hit),
    .valid     (valid),
    .dirty     (dirty),
    .rd        (rd),
    .wr        (wr),
    .sel_all   (sel_all),
    .dirty_wr  (dirty_wr),
    .adr_sel   (adr_sel),
    .m_rd      (m_rd),
    .m_wr      (m_wr),
    .m_ready   (m_ready),
`ifdef CACHE_STATS_EN
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
`endif
    .lru_update(lru_update)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; Hit = 1'b0;
    valid = 1'b0; dirty = 1'b0; m_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ov !== O_ZERO) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", ov, O_ZERO);
    end
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_cnt !== 4'd0 || miss_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_counters got=%0d/%0d exp=0/0", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_idle_mready();
    m_ready = 1'b1;
    tick();
    checks++;
    if (ov !== O_ZERO) begin
      failures++;
      $display("FAIL idle_mready_ignored got=%b exp=%b", ov, O_ZERO);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_read_hit();
    cpu_rd = 1'b1; Hit = 1'b1;
    tick();
    checks++;
    if (ov !== O_RDHIT) begin
      failures++;
      $display("FAIL read_hit_cmp got=%b exp=%b", ov, O_RDHIT);
    end
    cpu_rd = 1'b0;
    tick();
    checks++;
    if (ov !== O_ZERO) begin
      failures++;
      $display("FAIL read_hit_single_pulse got=%b exp=%b", ov, O_ZERO);
    end
  endtask

  task automatic test_write_hit();
    // Both asserted: write takes priority.
    cpu_rd = 1'b1; cpu_wr = 1'b1; Hit = 1'b1;
    tick();
    checks++;
    if (ov !== O_WRHIT) begin
      failures++;
      $display("FAIL write_hit_cmp got=%b exp=%b", ov, O_WRHIT);
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    tick();
    checks++;
    if (ov !== O_ZERO) begin
      failures++;
      $display("FAIL write_hit_idle got=%b exp=%b", ov, O_ZERO);
    end
  endtask

  task automatic test_clean_miss();
    do_reset();
    cpu_rd = 1'b1; Hit = 1'b0; valid = 1'b1; dirty = 1'b0;
    tick();
    checks++;
    if (ov !== O_CMPMIS) begin
      failures++;
      $display("FAIL clean_miss_cmp got=%b exp=%b", ov, O_CMPMIS);
    end
    cpu_rd = 1'b0; // request drops; transaction must still complete
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (ov !== O_ALLOC) begin
        failures++;
        $display("FAIL clean_miss_alloc%0d got=%b exp=%b", i, ov, O_ALLOC);
      end
    end
    tick();
    m_ready = 1'b1;
    #1;
    checks++;
    if (ov !== O_REFILL) begin
      failures++;
      $display("FAIL clean_miss_refill got=%b exp=%b", ov, O_REFILL);
    end
    Hit = 1'b1;
    tick();
    m_ready = 1'b0;
    #1;
    checks++;
    if (ov !== O_RDHIT) begin
      failures++;
      $display("FAIL clean_miss_ready got=%b exp=%b", ov, O_RDHIT);
    end
    tick();
    checks++;
    if (ov !== O_ZERO) begin
      failures++;
      $display("FAIL clean_miss_idle got=%b exp=%b", ov, O_ZERO);
    end
`ifdef CACHE_STATS_EN
    checks++;
    if (miss_cnt !== 4'd1 || hit_cnt !== 4'd0) begin
      failures++;
      $display("FAIL clean_miss_counts got=%0d/%0d exp=hit0/miss1", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_dirty_miss();
    cpu_wr = 1'b1; Hit = 1'b0; valid = 1'b1; dirty = 1'b1;
    tick();
    cpu_wr = 1'b0;
    checks++;
    if (ov !== O_CMPMIS) begin
      failures++;
      $display("FAIL dirty_miss_cmp got=%b exp=%b", ov, O_CMPMIS);
    end
    tick();
    checks++;
    if (ov !== O_WB) begin
      failures++;
      $display("FAIL dirty_miss_wb got=%b exp=%b", ov, O_WB);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    #1;
    checks++;
    if (ov !== O_ALLOC) begin
      failures++;
      $display("FAIL dirty_miss_alloc got=%b exp=%b", ov, O_ALLOC);
    end
    m_ready = 1'b1;
    #1;
    checks++;
    if (ov !== O_REFILL) begin
      failures++;
      $display("FAIL dirty_miss_refill got=%b exp=%b", ov, O_REFILL);
    end
    // Re-check still misses on a dirty line: must go back to WRITEBACK.
    tick();
    m_ready = 1'b0;
    #1;
    checks++;
    if (ov !== O_CMPMIS) begin
      failures++;
      $display("FAIL refault_cmp got=%b exp=%b", ov, O_CMPMIS);
    end
    tick();
    checks++;
    if (ov !== O_WB) begin
      failures++;
      $display("FAIL refault_wb got=%b exp=%b", ov, O_WB);
    end
    m_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (ov !== O_REFILL) begin
      failures++;
      $display("FAIL refault_refill got=%b exp=%b", ov, O_REFILL);
    end
    Hit = 1'b1;
    tick();
    m_ready = 1'b0;
    #1;
    // Write request: word write with dirty=1 on the final hit.
    checks++;
    if (ov !== O_WRHIT) begin
      failures++;
      $display("FAIL dirty_miss_done got=%b exp=%b", ov, O_WRHIT);
    end
    tick();
`ifdef CACHE_STATS_EN
    checks++;
    if (miss_cnt !== 4'd2 || hit_cnt !== 4'd0) begin
      failures++;
      $display("FAIL dirty_miss_counts got=%0d/%0d exp=hit0/miss2", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_alloc();
    cpu_rd = 1'b1; Hit = 1'b0; valid = 1'b1; dirty = 1'b0;
    tick();
    cpu_rd = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (ov !== O_ALLOC) begin
      failures++;
      $display("FAIL rst_alloc_pre got=%b exp=%b", ov, O_ALLOC);
    end
    rst = 1'b1; m_ready = 1'b1;
    #1;
    checks++;
    if (wr !== 1'b0) begin
      failures++;
      $display("FAIL rst_alloc_no_wr got=%b exp=0", wr);
    end
    tick();
    checks++;
    if (ov !== O_ZERO) begin
      failures++;
      $display("FAIL rst_alloc_after got=%b exp=%b", ov, O_ZERO);
    end
    rst = 1'b0;
    tick();
    m_ready = 1'b0;
    #1;
    checks++;
    if (ov !== O_ZERO) begin
      failures++;
      $display("FAIL rst_alloc_idle got=%b exp=%b", ov, O_ZERO);
    end
  endtask

`ifdef CACHE_STATS_EN
  task automatic test_saturation();
    do_reset();
    Hit = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cpu_rd = 1'b1;
      tick();
      cpu_rd = 1'b0;
      tick();
    end
    checks++;
    if (hit_cnt !== 4'd15 || miss_cnt !== 4'd0) begin
      failures++;
      $display("FAIL saturation got=%0d/%0d exp=hit15/miss0", hit_cnt, miss_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle_mready();
    test_read_hit();
    test_write_hit();
    test_clean_miss();
    test_dirty_miss();
    test_reset_mid_alloc();
`ifdef CACHE_STATS_EN
    test_saturation();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
